// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester/FIFO-write bundle shared by the arbiter and its clients.
// slave  = arbiter side (samples requests, drives the FIFO write port).
// master = requesters plus FIFO side (drives requests and the full flag).
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          fifo_full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          busy;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, wr_en, data_in, busy
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, wr_en, data_in, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin owner of the async FIFO write port (wrclk domain).
// Optional macro FIFO_ARB_BURST_EN: an owner keeps the port for up to MAX_BURST
// transfers; without it every transfer re-arbitrates (word-level round robin).
// wr_en/gnt/data_in are combinational from registered state, req and fifo_full.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input logic              wrclk,
    input logic              wrrst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned OW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_cfg_check
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_owner_q, last_owner_d;
    logic [OW-1:0] base;
    logic [OW-1:0] sel;
    logic          sel_vld;
    logic          wr_en;
    logic          release_own;

`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
`endif

    // Round-robin pick: scan upward from one past the base, wrapping mod NUM_REQ.
    // In GRANT the base is the current owner, since on release it becomes
    // last_owner at this same edge and must get lowest priority.
    always_comb begin
        int unsigned   idx;
        logic [OW-1:0] cand;
        base    = (state_q == GRANT) ? owner_q : last_owner_q;
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(base) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = OW'(idx);
            if (!sel_vld && bus.req[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    // Next-state: grant on any request from IDLE, release on req drop or burst end.
    always_comb begin
        wr_en        = (state_q == GRANT) && bus.req[owner_q] && !bus.fifo_full;
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        release_own  = 1'b0;
`ifdef FIFO_ARB_BURST_EN
        burst_cnt_d  = wr_en ? burst_cnt_q + BW'(1) : burst_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d     = GRANT;
                    owner_d     = sel;
`ifdef FIFO_ARB_BURST_EN
                    burst_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
`ifdef FIFO_ARB_BURST_EN
                release_own = !bus.req[owner_q] ||
                              (wr_en && (burst_cnt_q == BW'(MAX_BURST - 1)));
`else
                release_own = !bus.req[owner_q] || wr_en;
`endif
                if (release_own) begin
                    last_owner_d = owner_q;
                    if (sel_vld) begin
                        owner_d     = sel;
`ifdef FIFO_ARB_BURST_EN
                        burst_cnt_d = '0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-port outputs: one-hot grant and data mux for the current owner.
    always_comb begin
        bus.gnt          = '0;
        bus.gnt[owner_q] = wr_en;
        bus.data_in      = wr_en ? bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign bus.wr_en = wr_en;
    assign bus.busy  = (state_q == GRANT);

    // State registers; reset leaves requester 0 with first priority.
    always_ff @(posedge wrclk or negedge wrrst_n) begin
        if (!wrrst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
`ifdef FIFO_ARB_BURST_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter (4 requesters, 8-bit data).
// Expected grant order follows the build: bursts of 4 with FIFO_ARB_BURST_EN, else 1.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned BURST = MB;
`else
    localparam int unsigned BURST = 1;
`endif

    typedef struct {
        int unsigned id;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .wrclk  (clk),
        .wrrst_n(rst_n),
        .bus    (bus)
    );

    exp_t          exp_q[$];
    logic [7:0]    fifo_q[$];
    int unsigned   left[NR];
    int unsigned   sent[NR];
    logic [NR-1:0] g_seen;
    int            n_checks = 0;
    int            n_fail   = 0;

    // Word k of requester i: id in the top two bits.
    function automatic logic [7:0] word(int unsigned i, int unsigned k);
        return 8'((i << 6) | (k & 63));
    endfunction

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            bus.req[i]              = (left[i] != 0);
            bus.req_data[i*DW +: DW] = word(i, sent[i]);
        end
    endtask

    // Advance one edge; requesters granted at that edge move to their next word.
    task automatic step(input logic full);
        g_seen = bus.gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (g_seen[i]) begin
                sent[i]++;
                left[i]--;
            end
        end
        bus.fifo_full = full;
        apply();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) begin
            left[i] = 0;
            sent[i] = 0;
        end
        bus.fifo_full = 1'b0;
        apply();
        exp_q.delete();
        fifo_q.delete();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) left[i] = 3;
        apply();
        @(negedge clk);
        n_checks++;
        if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b, required 0", bus.wr_en); end
        n_checks++;
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b, required 0000", bus.gnt); end
        n_checks++;
        if (bus.data_in !== 8'h00) begin n_fail++; $display("FAIL reset_data_in: got %h, required 00", bus.data_in); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        do_reset();
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        bus.req      = 4'b0001;
        bus.req_data = '0;
        bus.req_data[7:0] = 8'hA5;
        exp_q.push_back('{0, 8'hA5});
        @(negedge clk);
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_cycle: wr_en=%b busy=%b, required 0 0", bus.wr_en, bus.busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        e = exp_q.pop_front();
        if (bus.gnt !== 4'b0001 || bus.wr_en !== 1'b1 || bus.data_in !== e.data) begin
            n_fail++; $display("FAIL single_grant: gnt=%b wr_en=%b data=%h, required 0001 1 %h", bus.gnt, bus.wr_en, bus.data_in, e.data);
        end
        @(posedge clk); #1 bus.req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL single_drop_cycle: wr_en=%b busy=%b, required 0 1", bus.wr_en, bus.busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL single_back_idle: busy=%b gnt=%b, required 0 0000", bus.busy, bus.gnt);
        end
        bus.req = '0;
    endtask

    task automatic test_all_hold();
        int          xfers = 0;
        int          bubbles = 0;
        int unsigned cnt[NR] = '{default: 0};
        logic [NR-1:0] eg;
        exp_t        e;
        do_reset();
        for (int i = 0; i < NR; i++) left[i] = 24;
        apply();
        for (int n = 0; n < 20; n++) begin
            int unsigned id;
            id = (n / BURST) % NR;
            exp_q.push_back('{id, word(id, cnt[id])});
            cnt[id]++;
        end
        for (int cyc = 0; cyc < 60 && xfers < 20; cyc++) begin
            @(negedge clk);
            if (bus.wr_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL all_hold_extra: unexpected write data=%h", bus.data_in);
                end else begin
                    e = exp_q.pop_front();
                    eg = '0; eg[e.id] = 1'b1;
                    if (bus.gnt !== eg || bus.data_in !== e.data) begin
                        n_fail++; $display("FAIL all_hold_word%0d: gnt=%b data=%h, required %b %h", xfers, bus.gnt, bus.data_in, eg, e.data);
                    end
                end
                xfers++;
            end else if (xfers > 0) begin
                bubbles++;
            end
            step(1'b0);
        end
        n_checks++;
        if (xfers != 20) begin n_fail++; $display("FAIL all_hold_count: got %0d words, required 20", xfers); end
        n_checks++;
        if (bubbles != 0) begin n_fail++; $display("FAIL all_hold_bubbles: got %0d, required 0", bubbles); end
    endtask

    task automatic test_fifo_full_stall();
        int          xfers = 0;
        int          stalls = 0;
        int          bubbles = 0;
        int          full_left = 0;
        bit          armed = 1'b1;
        int unsigned cnt[NR] = '{default: 0};
        logic [NR-1:0] eg;
        exp_t        e;
        do_reset();
        left[2] = 4;
        left[3] = 4;
        apply();
        for (int n = 0; n < 8; n++) begin
            int unsigned id;
            id = 2 + (n / BURST) % 2;
            exp_q.push_back('{id, word(id, cnt[id])});
            cnt[id]++;
        end
        for (int cyc = 0; cyc < 40 && xfers < 8; cyc++) begin
            @(negedge clk);
            if (bus.fifo_full) begin
                stalls++;
                n_checks++;
                if (bus.wr_en !== 1'b0 || bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
                    n_fail++; $display("FAIL stall_outputs: wr_en=%b gnt=%b busy=%b, required 0 0000 1", bus.wr_en, bus.gnt, bus.busy);
                end
            end else if (bus.wr_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra: unexpected write data=%h", bus.data_in);
                end else begin
                    e = exp_q.pop_front();
                    eg = '0; eg[e.id] = 1'b1;
                    if (bus.gnt !== eg || bus.data_in !== e.data) begin
                        n_fail++; $display("FAIL stall_word%0d: gnt=%b data=%h, required %b %h", xfers, bus.gnt, bus.data_in, eg, e.data);
                    end
                end
                xfers++;
            end else if (xfers > 0) begin
                bubbles++;
            end
            if (xfers == 2 && armed) begin
                armed = 1'b0;
                full_left = 3;
            end
            step(full_left != 0);
            if (full_left > 0) full_left--;
        end
        n_checks++;
        if (xfers != 8) begin n_fail++; $display("FAIL stall_count: got %0d words, required 8", xfers); end
        n_checks++;
        if (stalls != 3) begin n_fail++; $display("FAIL stall_cycles: got %0d, required 3", stalls); end
        n_checks++;
        if (bubbles != 0) begin n_fail++; $display("FAIL stall_bubbles: got %0d, required 0", bubbles); end
    endtask

    task automatic test_single_requester();
        int   xfers = 0;
        int   bubbles = 0;
        exp_t e;
        do_reset();
        left[1] = 10;
        apply();
        for (int k = 0; k < 10; k++) exp_q.push_back('{1, word(1, k)});
        for (int cyc = 0; cyc < 40 && xfers < 10; cyc++) begin
            @(negedge clk);
            if (bus.wr_en) begin
                n_checks++;
                e = exp_q.pop_front();
                if (bus.gnt !== 4'b0010 || bus.data_in !== e.data) begin
                    n_fail++; $display("FAIL solo_word%0d: gnt=%b data=%h, required 0010 %h", xfers, bus.gnt, bus.data_in, e.data);
                end
                xfers++;
            end else if (xfers > 0) begin
                bubbles++;
            end
            step(1'b0);
        end
        n_checks++;
        if (xfers != 10) begin n_fail++; $display("FAIL solo_count: got %0d words, required 10", xfers); end
        n_checks++;
        if (bubbles != 0) begin n_fail++; $display("FAIL solo_bubbles: got %0d, required 0", bubbles); end
        @(negedge clk);
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL solo_drop_cycle: wr_en=%b busy=%b, required 0 1", bus.wr_en, bus.busy);
        end
        step(1'b0);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL solo_idle: busy=%b, required 0", bus.busy); end
    endtask

    task automatic test_reset_mid_burst();
        int            xfers = 0;
        bit            hit = 1'b0;
        int unsigned   cnt[NR] = '{default: 0};
        logic [NR-1:0] eg;
        logic [7:0]    want;
        exp_t          e;
        do_reset();
        for (int i = 0; i < NR; i++) left[i] = 20;
        apply();
        for (int n = 0; n < 2; n++) begin
            int unsigned id;
            id = (n / BURST) % NR;
            exp_q.push_back('{id, word(id, cnt[id])});
            cnt[id]++;
        end
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            @(negedge clk);
            if (bus.wr_en && xfers == 2) begin
                hit = 1'b1;
            end else begin
                if (bus.wr_en) begin
                    n_checks++;
                    e = exp_q.pop_front();
                    eg = '0; eg[e.id] = 1'b1;
                    if (bus.gnt !== eg || bus.data_in !== e.data) begin
                        n_fail++; $display("FAIL rst_pre_word%0d: gnt=%b data=%h, required %b %h", xfers, bus.gnt, bus.data_in, eg, e.data);
                    end
                    xfers++;
                end
                step(1'b0);
            end
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL rst_no_inflight: got %0d words, required a third in flight", xfers); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.wr_en !== 1'b0 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_immediate: wr_en=%b gnt=%b busy=%b, required 0 0000 0", bus.wr_en, bus.gnt, bus.busy);
        end
        #1 rst_n = 1'b1;
        step(1'b0);
        @(negedge clk);
        want = (BURST > 1) ? word(0, 2) : word(0, 1);
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.data_in !== want) begin
            n_fail++; $display("FAIL rst_first_grant: gnt=%b data=%h, required 0001 %h", bus.gnt, bus.data_in, want);
        end
    endtask

    task automatic test_random_fifo();
        int          rd_pct = 60;
        bit          rd;
        bit          done = 1'b0;
        logic [7:0]  got;
        exp_t        e;
        do_reset();
        for (int cyc = 0; cyc < 1400 && !done; cyc++) begin
            int unsigned id;
            @(negedge clk);
            n_checks++;
            if ($countones(bus.gnt) != (bus.wr_en ? 1 : 0)) begin
                n_fail++; $display("FAIL rand_gnt_onehot: gnt=%b wr_en=%b", bus.gnt, bus.wr_en);
            end
            if (bus.wr_en) begin
                n_checks++;
                if (bus.fifo_full) begin
                    n_fail++; $display("FAIL rand_write_when_full: wr_en=1 with fifo_full=1, required wr_en=0");
                end
                id = 0;
                for (int i = 0; i < NR; i++) if (bus.gnt[i]) id = i;
                exp_q.push_back('{id, word(id, sent[id])});
            end
            if (cyc % 100 == 0) rd_pct = int'($urandom_range(20, 90));
            rd = (fifo_q.size() > 0) && (cyc >= 1000 || $urandom_range(0, 99) < rd_pct);
            if (rd) begin
                got = fifo_q.pop_front();
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e.data) begin
                    n_fail++; $display("FAIL rand_fifo_read: got %h, required %h (requester %0d)", got, e.data, e.id);
                end
            end
            if (bus.wr_en) fifo_q.push_back(bus.data_in);
            step(fifo_q.size() >= 8);
            if (cyc < 1000) begin
                for (int i = 0; i < NR; i++) begin
                    if (left[i] == 0 && $urandom_range(0, 3) == 0) left[i] = $urandom_range(1, 6);
                end
                apply();
            end else begin
                done = (fifo_q.size() == 0) && (left[0] == 0) && (left[1] == 0) &&
                       (left[2] == 0) && (left[3] == 0);
            end
        end
        n_checks++;
        if (!done || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: done=%0b pending=%0d, required 1 0", done, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.fifo_full = 1'b0;
        test_reset();
        test_single();
        test_all_hold();
        test_fifo_full_stall();
        test_single_requester();
        test_reset_mid_burst();
        test_random_fifo();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
